// File: rtl/ripple_count_capture_if.sv
// Record channel from the ripple counter capture block.
// The producer drives valid and payload; the consumer drives ready.
interface ripple_count_capture_if #(
  parameter int CNT_W   = 4,
  parameter int TOTAL_W = 16
);
  logic               out_valid;
  logic               out_ready;
  logic [CNT_W:0]     out_delta;
  logic [TOTAL_W-1:0] out_total;
  logic               out_wrap;

  modport master (
    output out_valid, out_delta, out_total, out_wrap,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_delta, out_total, out_wrap,
    output out_ready
  );
endinterface

// File: rtl/ripple_count_capture.sv
// Samples a glitchy ripple counter value, accepts only values held stable, and
// emits (delta, running total, wrap) records with backlog coalescing under backpressure.
module ripple_count_capture #(
  parameter int CNT_W         = 4,
  parameter int TOTAL_W       = 16,
  parameter int STABLE_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic [CNT_W-1:0]  Q_in,
  input  logic              clear,
  ripple_count_capture_if.master o_rec,
  output logic              overflow
);

  localparam int SW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, HOLD, HOLD_BL} stateT;

  stateT              r_state, w_stateNext;
  logic [CNT_W-1:0]   r_s1, r_s2, r_s2Prev, r_lastVal, w_lastValNext;
  logic [SW-1:0]      r_stabCnt, w_stabNext;
  logic [TOTAL_W-1:0] r_total, w_totalNext, w_totalNew;
  logic [TOTAL_W-1:0] r_outTotal, w_outTotalNext;
  logic [CNT_W:0]     r_acc, w_accNext, r_delta, w_deltaNext, w_accSat;
  logic [CNT_W+1:0]   w_accSum;
  logic               r_accw, w_accwNext, r_overflow, w_ovfNext;
  logic               r_wrap, w_wrapNext;
  logic               w_commit, w_dWrap, w_accOvf;
  logic [CNT_W-1:0]   w_d;

  // A stale saturated count must not accept a freshly changed sample, hence the s2==s2Prev term.
  assign w_commit   = (r_s2 == r_s2Prev) && (r_stabCnt == STAB_MAX) && (r_s2 != r_lastVal);
  assign w_d        = r_s2 - r_lastVal;
  assign w_dWrap    = (r_s2 < r_lastVal);
  assign w_totalNew = r_total + {{(TOTAL_W-CNT_W){1'b0}}, w_d};
  assign w_accSum   = {1'b0, r_acc} + {2'b00, (w_commit ? w_d : '0)};
  assign w_accOvf   = w_accSum[CNT_W+1];
  assign w_accSat   = w_accOvf ? '1 : w_accSum[CNT_W:0];

  always_comb begin
    w_stateNext    = r_state;
    w_deltaNext    = r_delta;
    w_outTotalNext = r_outTotal;
    w_wrapNext     = r_wrap;
    w_accNext      = r_acc;
    w_accwNext     = r_accw;
    w_ovfNext      = r_overflow;
    w_totalNext    = w_commit ? w_totalNew : r_total;
    w_lastValNext  = w_commit ? r_s2 : r_lastVal;
    if (r_s2 != r_s2Prev)
      w_stabNext = SW'(1);
    else if (r_stabCnt == STAB_MAX)
      w_stabNext = STAB_MAX;
    else
      w_stabNext = r_stabCnt + SW'(1);

    case (r_state)
      IDLE: begin
        if (w_commit) begin
          w_deltaNext    = {1'b0, w_d};
          w_outTotalNext = w_totalNew;
          w_wrapNext     = w_dWrap;
          w_stateNext    = HOLD;
        end
      end
      HOLD: begin
        if (o_rec.out_ready) begin
          if (w_commit) begin
            w_deltaNext    = {1'b0, w_d};
            w_outTotalNext = w_totalNew;
            w_wrapNext     = w_dWrap;
          end else begin
            w_stateNext = IDLE;
          end
        end else if (w_commit) begin
          w_accNext   = w_accSat;
          w_accwNext  = r_accw | w_dWrap;
          w_ovfNext   = r_overflow | w_accOvf;
          w_stateNext = HOLD_BL;
        end
      end
      HOLD_BL: begin
        // The handshake edge folds any same-cycle commit into the backlog record.
        if (o_rec.out_ready) begin
          w_deltaNext    = w_accSat;
          w_outTotalNext = w_totalNext;
          w_wrapNext     = r_accw | (w_commit & w_dWrap);
          w_ovfNext      = r_overflow | w_accOvf;
          w_accNext      = '0;
          w_accwNext     = 1'b0;
          w_stateNext    = HOLD;
        end else if (w_commit) begin
          w_accNext  = w_accSat;
          w_accwNext = r_accw | w_dWrap;
          w_ovfNext  = r_overflow | w_accOvf;
        end
      end
      default: w_stateNext = IDLE;
    endcase

    // last_val still advances on a dropped commit so the same value is not re-reported.
    if (clear) begin
      w_stateNext    = IDLE;
      w_totalNext    = '0;
      w_accNext      = '0;
      w_accwNext     = 1'b0;
      w_ovfNext      = 1'b0;
      w_deltaNext    = '0;
      w_outTotalNext = '0;
      w_wrapNext     = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      r_state    <= IDLE;
      r_s1       <= '0;
      r_s2       <= '0;
      r_s2Prev   <= '0;
      r_stabCnt  <= '0;
      r_lastVal  <= '0;
      r_total    <= '0;
      r_outTotal <= '0;
      r_delta    <= '0;
      r_wrap     <= 1'b0;
      r_acc      <= '0;
      r_accw     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_s1       <= Q_in;
      r_s2       <= r_s1;
      r_s2Prev   <= r_s2;
      r_stabCnt  <= w_stabNext;
      r_lastVal  <= w_lastValNext;
      r_total    <= w_totalNext;
      r_outTotal <= w_outTotalNext;
      r_delta    <= w_deltaNext;
      r_wrap     <= w_wrapNext;
      r_acc      <= w_accNext;
      r_accw     <= w_accwNext;
      r_overflow <= w_ovfNext;
    end
  end

  assign o_rec.out_valid = (r_state != IDLE);
  assign o_rec.out_delta = r_delta;
  assign o_rec.out_total = r_outTotal;
  assign o_rec.out_wrap  = r_wrap;
  assign overflow        = r_overflow;

endmodule
